// File: rtl/mul_pkg.sv
// Shared definitions for the 2-bit multiplier and its on-board self-test sequencer.
// Holds the sweep state encoding, the default operand width and width helpers.
package mul_pkg;

   localparam int OPW_DEF = 2;
   localparam int PW_DEF  = 2 * OPW_DEF;
   localparam int NV_DEF  = 1 << (2 * OPW_DEF);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;

   function automatic int pw_of(input int opw);
      return 2 * opw;
   endfunction

   function automatic int nv_of(input int opw);
      return 1 << (2 * opw);
   endfunction

   // Settle counter only needs to reach SETTLE_CYCLES-1; keep at least one bit.
   function automatic int cnt_w_of(input int settle);
      return (settle > 1) ? $clog2(settle) : 1;
   endfunction

endpackage

// File: rtl/mul_selftest_seq.sv
// Self-test sequencer: sweeps every operand pair through the external multiplier,
// waits a settle interval, compares product_in to a*b and records results.
module mul_selftest_seq
   import mul_pkg::*;
#(
   parameter int OPW           = OPW_DEF,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [OPW-1:0]       a_out,
   output logic [OPW-1:0]       b_out,
   input  logic [2*OPW-1:0]     product_in,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2*OPW:0]       err_count,
   output logic                 fail_valid,
   output logic [OPW-1:0]       fail_a,
   output logic [OPW-1:0]       fail_b,
   output logic [2*OPW-1:0]     fail_product
);

   localparam int PW = pw_of(OPW);
   localparam int IW = 2 * OPW;
   localparam int EW = 2 * OPW + 1;
   localparam int CW = cnt_w_of(SETTLE_CYCLES);

   localparam logic [IW-1:0] IDX_LAST    = {IW{1'b1}};
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

   if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("mul_selftest_seq: SETTLE_CYCLES must be >= 1");
   end

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [EW-1:0]   err_q, err_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic            fv_q, fv_d;
   logic [OPW-1:0]  fa_q, fa_d;
   logic [OPW-1:0]  fb_q, fb_d;
   logic [PW-1:0]   fp_q, fp_d;

   logic            accept;
   logic            mismatch;
   logic [PW-1:0]   expected;
   logic [EW-1:0]   err_inc;

   // Operands come straight from the vector index so they are registered by construction.
   assign a_out = idx_q[IW-1:OPW];
   assign b_out = idx_q[OPW-1:0];

   assign expected = {{OPW{1'b0}}, a_out} * {{OPW{1'b0}}, b_out};
   assign mismatch = (product_in != expected);
   assign err_inc  = err_q + {{(EW-1){1'b0}}, mismatch};
   assign accept   = start && ((state_q == IDLE) || (state_q == DONE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fv_q    <= 1'b0;
         fa_q    <= '0;
         fb_q    <= '0;
         fp_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         fv_q    <= fv_d;
         fa_q    <= fa_d;
         fb_q    <= fb_d;
         fp_q    <= fp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      done_d  = done_q;
      pass_d  = pass_q;
      fv_d    = fv_q;
      fa_d    = fa_q;
      fb_d    = fb_q;
      fp_d    = fp_q;

      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               state_d = SETTLE;
               idx_d   = '0;
               cnt_d   = '0;
               err_d   = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               fv_d    = 1'b0;
               fa_d    = '0;
               fb_d    = '0;
               fp_d    = '0;
            end
         end
         SETTLE: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == SETTLE_LAST) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            err_d = err_inc;
            if (mismatch && !fv_q) begin
               fv_d = 1'b1;
               fa_d = a_out;
               fb_d = b_out;
               fp_d = product_in;
            end
            // pass reflects the count including this cycle's comparison.
            if (idx_q == IDX_LAST) begin
               state_d = DONE;
               done_d  = 1'b1;
               pass_d  = (err_inc == '0);
            end else begin
               state_d = SETTLE;
               idx_d   = idx_q + IW'(1);
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      busy = (state_q == SETTLE) || (state_q == CHECK);
   end

   assign done         = done_q;
   assign pass         = pass_q;
   assign err_count    = err_q;
   assign fail_valid   = fv_q;
   assign fail_a       = fa_q;
   assign fail_b       = fb_q;
   assign fail_product = fp_q;

endmodule

// File: tb/tb_mul_selftest_seq.sv
// Bench for mul_selftest_seq: a table-driven multiplier model (good or faulty) feeds
// product_in; a nested-loop reference predicts each sweep's results.
module tb_mul_selftest_seq;

   localparam int OPW   = 2;
   localparam int SWEEP = 48;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   a_out, b_out;
   logic [3:0]   product_in;
   logic         busy, done, pass, fail_valid;
   logic [4:0]   err_count;
   logic [1:0]   fail_a, fail_b;
   logic [3:0]   fail_product;

   logic [3:0]   prod_tbl [16];
   logic [14:0]  exp_q [$];
   int           n_checks = 0;
   int           n_fail   = 0;

   mul_selftest_seq #(.OPW(OPW), .SETTLE_CYCLES(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .a_out        (a_out),
      .b_out        (b_out),
      .product_in   (product_in),
      .busy         (busy),
      .done         (done),
      .pass         (pass),
      .err_count    (err_count),
      .fail_valid   (fail_valid),
      .fail_a       (fail_a),
      .fail_b       (fail_b),
      .fail_product (fail_product)
   );

   always #5 clk = ~clk;

   always_comb product_in = prod_tbl[{a_out, b_out}];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_good();
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            prod_tbl[a*4+b] = 4'(a * b);
   endtask

   task automatic set_stuck0();
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            prod_tbl[a*4+b] = 4'(a * b) & 4'hE;
   endtask

   task automatic set_const_f();
      for (int i = 0; i < 16; i++) prod_tbl[i] = 4'hF;
   endtask

   task automatic set_random(input int nflip);
      int k;
      set_good();
      for (int i = 0; i < nflip; i++) begin
         k = $urandom_range(0, 15);
         prod_tbl[k] = prod_tbl[k] ^ 4'($urandom_range(1, 15));
      end
   endtask

   // Reference: walk the vectors in a-major order, compare to a*b, keep the first miss.
   task automatic model_push();
      int         errs = 0;
      logic       fv = 1'b0;
      logic [1:0] fa = '0, fb = '0;
      logic [3:0] fp = '0;
      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            if (prod_tbl[a*4+b] != 4'(a * b)) begin
               errs++;
               if (!fv) begin
                  fv = 1'b1;
                  fa = 2'(a);
                  fb = 2'(b);
                  fp = prod_tbl[a*4+b];
               end
            end
         end
      end
      exp_q.push_back({(errs == 0), fv, fa, fb, fp, 5'(errs)});
   endtask

   task automatic check_results(input string tag, input logic [14:0] e);
      check({tag, ".pass"},     32'(pass),         32'(e[14]));
      check({tag, ".fvalid"},   32'(fail_valid),   32'(e[13]));
      check({tag, ".fail_a"},   32'(fail_a),       32'(e[12:11]));
      check({tag, ".fail_b"},   32'(fail_b),       32'(e[10:9]));
      check({tag, ".fail_p"},   32'(fail_product), 32'(e[8:5]));
      check({tag, ".errs"},     32'(err_count),    32'(e[4:0]));
   endtask

   task automatic run_sweep(input string tag, input int restart_at, output logic [14:0] e);
      int cyc = 0;
      int busy_n = 0;
      model_push();
      e = exp_q.pop_front();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check({tag, ".acc_done"}, 32'(done), 32'd0);
      check({tag, ".acc_errs"}, 32'(err_count), 32'd0);
      check({tag, ".acc_fv"},   32'(fail_valid), 32'd0);
      while (!done && cyc < 200) begin
         if (busy) busy_n++;
         start = (cyc == restart_at);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check({tag, ".latency"}, 32'(cyc), 32'(SWEEP));
      check({tag, ".busy_n"},  32'(busy_n), 32'(SWEEP));
      check({tag, ".done"},    32'(done), 32'd1);
      check({tag, ".busy"},    32'(busy), 32'd0);
      check({tag, ".a_out"},   32'(a_out), 32'd3);
      check({tag, ".b_out"},   32'(b_out), 32'd3);
      check_results(tag, e);
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".busy"},   32'(busy), 32'd0);
      check({tag, ".done"},   32'(done), 32'd0);
      check({tag, ".pass"},   32'(pass), 32'd0);
      check({tag, ".a_out"},  32'(a_out), 32'd0);
      check({tag, ".b_out"},  32'(b_out), 32'd0);
      check({tag, ".errs"},   32'(err_count), 32'd0);
      check({tag, ".fvalid"}, 32'(fail_valid), 32'd0);
      check({tag, ".fail_a"}, 32'(fail_a), 32'd0);
      check({tag, ".fail_b"}, 32'(fail_b), 32'd0);
      check({tag, ".fail_p"}, 32'(fail_product), 32'd0);
   endtask

   initial begin
      logic [14:0] e;
      rst   = 1'b1;
      start = 1'b0;
      set_good();
      #1;
      check_zero("reset");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_zero("idle");

      run_sweep("good", -1, e);
      set_const_f();
      repeat (5) @(negedge clk);
      check("hold.done", 32'(done), 32'd1);
      check_results("hold", e);

      set_stuck0();
      run_sweep("stuck0", -1, e);
      set_const_f();
      run_sweep("const_f", -1, e);
      set_good();
      run_sweep("restart10", 10, e);

      set_stuck0();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (20) @(negedge clk);
      check("pre_rst.busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check_zero("mid_rst");
      @(negedge clk); rst = 1'b0;
      repeat (4) @(negedge clk);
      check_zero("post_rst");
      set_good();
      run_sweep("after_rst", -1, e);

      set_stuck0();
      run_sweep("fix_a", -1, e);
      set_good();
      run_sweep("fix_b", -1, e);

      for (int r = 0; r < 6; r++) begin
         set_random($urandom_range(1, 5));
         run_sweep($sformatf("rand%0d", r), -1, e);
      end

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
